jpeg_block_raster_buffer: RTL and testbench
===========================================

Name: jpeg_block_raster_buffer

Overview:
- Downstream of the 8x8 block serializer, which emits one 9-bit signed pixel per cycle in block row-major order with no backpressure.
- Per pixel: level-shifts by +128 and clamps to 0..255.
- Reorders one block-row strip (8 lines x BLOCKS_PER_ROW blocks) into raster order using a ping-pong pair of strip banks.
- Drains raster pixels through a valid/ready interface to the output/colour stage.

Parameters:
BLOCKS_PER_ROW, 4, 8x8 blocks per image row; line width W = 8*BLOCKS_PER_ROW pixels; strip size S = 8*W.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
sof  in  1  synchronous start-of-frame clear, single-cycle pulse
pixel_valid  in  1  input pixel strobe, no stall possible
pixel_in  in  9  signed pixel, block row-major (k = 0..63, row = k[5:3], col = k[2:0])
out_valid  out  1  raster pixel available
out_ready  in  1  consumer accepts on out_valid && out_ready
out_pixel  out  8  unsigned level-shifted, clamped pixel
out_eol  out  1  qualifies last pixel of a line (col == W-1)
out_eos  out  1  qualifies last pixel of a strip (index S-1)
overflow  out  1  sticky: an input pixel was dropped

Behaviour:
- Reset: clk and rst_n as above. All outputs are 0. Both banks are EMPTY. Write and read bank pointers are 0. All counters are 0.
- sof has the same effect as reset, applied synchronously. sof has priority over any pixel or handshake in the same cycle.
- Arithmetic: v = pixel_in + 128, computed at 10-bit signed. Then v < 0 -> 0, v > 255 -> 255, else v[7:0]. Clamping happens before storage; banks are 8 bits wide.
- Write side:
  - Counters: k (0..63), blk (0..BLOCKS_PER_ROW-1).
  - Address = k[5:3]*W + blk*8 + k[2:0] in bank wbank.
  - k wraps to 0 and increments blk. blk wraps to 0, marks wbank FULL and toggles wbank.
- Bank states: EMPTY -> FILLING (first write) -> FULL (last write, index 63 of last block) -> DRAINING (read starts) -> EMPTY (final out handshake).
  - A bank released by the final handshake in cycle N is writable from cycle N+1.
- Drop rule:
  - A pixel_valid arriving while wbank is FULL or DRAINING is not written.
  - The counters do not advance, and overflow is set until reset or sof.
  - Frame content after an overflow is undefined; the next sof recovers.
- Read side:
  - Sequential raster address 0..S-1 in rbank. Bank memory has 1-cycle registered read.
  - When rbank becomes FULL and the reader is idle, out_valid asserts exactly 2 cycles after the cycle of the final write.
- Output hold: while out_valid && !out_ready, out_pixel, out_eol and out_eos hold stable. No pixel is lost or duplicated.
- Throughput: with out_ready held at 1, the block sustains one pixel per cycle, including across the strip boundary into the other bank if that bank is FULL.
- After the out_eos handshake: rbank returns to EMPTY and toggles. out_valid deasserts the next cycle unless the other bank is FULL.
- Simultaneous events: a write to wbank and a read of rbank in the same cycle are independent, since they target different banks. Ping-pong guarantees wbank != rbank while both are active.
- Reset mid-operation (rst_n or sof): in-flight strips are discarded. out_valid drops immediately for rst_n, or at the next edge for sof.

Test Plan:
- Clamp, with out_ready = 1: pixel_in = -128, 127, 9'h138 (-200), 200 at chosen positions -> out_pixel = 0, 255, 0, 255 at the matching raster slots.
- Reorder, BLOCKS_PER_ROW = 2 (W = 16, S = 128):
  - Stimulus: block0 pixel k = k-128; block1 pixel k = (64+k)-128.
  - Required output: 0..7, 64..71, 8..15, 72..79, ..., 56..63, 120..127.
  - out_eol on outputs 16, 32, ..., 128; out_eos only on output 128.
  - First out_valid exactly 2 cycles after the last input.
- Backpressure: out_ready = 0 for 10 cycles starting at output 37 -> out_pixel/out_eol stable throughout; full 128-pixel sequence intact; overflow = 0.
- Ping-pong: two strips fed back-to-back, out_ready = 1 -> 256 outputs in order; strip 2 output continuous after strip 1 eos; overflow = 0.
- Overflow: out_ready = 0, feed 2 full strips plus 1 pixel -> third-strip pixel dropped, overflow = 1; raise out_ready -> both stored strips drain intact (256 pixels); overflow stays 1 until sof.
- Reset mid-drain: rst_n low for 2 cycles at output 50 -> out_valid = 0 and overflow = 0 immediately; a fresh strip then produces the correct 128-pixel sequence. Repeat with sof instead, same result.

Source files
------------

// File: rtl/jpeg_block_raster_buffer.sv
// Level-shifts/clamps block row-major pixels and reorders one block-row strip
// into raster order through a ping-pong pair of strip banks, drained valid/ready.
module jpeg_block_raster_buffer #(
    parameter int BLOCKS_PER_ROW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sof,
    input  logic       pixel_valid,
    input  logic [8:0] pixel_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pixel,
    output logic       out_eol,
    output logic       out_eos,
    output logic       overflow
);
    localparam int W     = 8 * BLOCKS_PER_ROW;
    localparam int S     = 8 * W;
    localparam int AW    = $clog2(S);
    localparam int CW    = $clog2(W);
    localparam int BW    = (BLOCKS_PER_ROW > 1) ? $clog2(BLOCKS_PER_ROW) : 1;
    localparam int DEPTH = 2 ** (AW + 1);

    localparam logic [1:0] BANK_EMPTY    = 2'd0;
    localparam logic [1:0] BANK_FILLING  = 2'd1;
    localparam logic [1:0] BANK_FULL     = 2'd2;
    localparam logic [1:0] BANK_DRAINING = 2'd3;

    localparam logic [BW-1:0] BLK_LAST  = BW'(BLOCKS_PER_ROW - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(S - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);

    function automatic logic [7:0] level_shift_clamp(input logic [8:0] p);
        logic [9:0] v;
        v = {p[8], p} + 10'd128;
        if (v[9]) begin
            return 8'd0;
        end else if (v[8]) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

    logic [7:0]      mem_q [DEPTH];
    logic [1:0][1:0] bank_st_q, bank_st_d;
    logic [5:0]      k_q, k_d;
    logic [BW-1:0]   blk_q, blk_d;
    logic            wbank_q, wbank_d;
    logic            ibank_q, ibank_d;
    logic            rbank_q, rbank_d;
    logic [AW-1:0]   iaddr_q, iaddr_d;
    logic [CW-1:0]   icol_q, icol_d;
    logic            out_valid_q, out_valid_d;
    logic            out_eol_q, out_eol_d;
    logic            out_eos_q, out_eos_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      out_pixel_q;

    logic            wr_ok_s, wr_en_s, wr_last_s, fire_s, issue_s;
    logic [AW-1:0]   waddr_s;

    assign wr_ok_s   = (bank_st_q[wbank_q] == BANK_EMPTY) || (bank_st_q[wbank_q] == BANK_FILLING);
    assign wr_en_s   = pixel_valid & wr_ok_s & ~sof;
    assign wr_last_s = (k_q == 6'd63) && (blk_q == BLK_LAST);
    assign waddr_s   = AW'(int'(k_q[5:3]) * W + int'({blk_q, 3'b000}) + int'(k_q[2:0]));
    assign fire_s    = out_valid_q & out_ready;
    // The issue pointer runs ahead of the release pointer so a FULL bank is read back-to-back.
    assign issue_s   = (~out_valid_q | out_ready) &
                       ((iaddr_q != '0) | (bank_st_q[ibank_q] == BANK_FULL));

    // Next-state for write counters, bank states, read issue and output stage
    always_comb begin
        k_d         = k_q;
        blk_d       = blk_q;
        wbank_d     = wbank_q;
        bank_st_d   = bank_st_q;
        ibank_d     = ibank_q;
        iaddr_d     = iaddr_q;
        icol_d      = icol_q;
        rbank_d     = rbank_q;
        out_valid_d = out_valid_q;
        out_eol_d   = out_eol_q;
        out_eos_d   = out_eos_q;
        overflow_d  = overflow_q;
        if (sof) begin
            k_d         = 6'd0;
            blk_d       = '0;
            wbank_d     = 1'b0;
            bank_st_d   = '0;
            ibank_d     = 1'b0;
            iaddr_d     = '0;
            icol_d      = '0;
            rbank_d     = 1'b0;
            out_valid_d = 1'b0;
            out_eol_d   = 1'b0;
            out_eos_d   = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            overflow_d = overflow_q | (pixel_valid & ~wr_ok_s);
            if (wr_en_s) begin
                if (wr_last_s) begin
                    k_d                = 6'd0;
                    blk_d              = '0;
                    wbank_d            = ~wbank_q;
                    bank_st_d[wbank_q] = BANK_FULL;
                end else if (k_q == 6'd63) begin
                    k_d                = 6'd0;
                    blk_d              = blk_q + BW'(1);
                    bank_st_d[wbank_q] = BANK_FILLING;
                end else begin
                    k_d                = k_q + 6'd1;
                    bank_st_d[wbank_q] = BANK_FILLING;
                end
            end else begin
                k_d = k_q;
            end
            if (issue_s) begin
                out_valid_d        = 1'b1;
                out_eol_d          = (icol_q == COL_LAST);
                out_eos_d          = (iaddr_q == ADDR_LAST);
                icol_d             = (icol_q == COL_LAST) ? '0 : icol_q + CW'(1);
                bank_st_d[ibank_q] = (iaddr_q == '0) ? BANK_DRAINING : bank_st_d[ibank_q];
                if (iaddr_q == ADDR_LAST) begin
                    iaddr_d = '0;
                    ibank_d = ~ibank_q;
                end else begin
                    iaddr_d = iaddr_q + AW'(1);
                    ibank_d = ibank_q;
                end
            end else begin
                out_valid_d = out_valid_q & ~fire_s;
            end
            if (fire_s && out_eos_q) begin
                bank_st_d[rbank_q] = BANK_EMPTY;
                rbank_d            = ~rbank_q;
            end else begin
                rbank_d = rbank_q;
            end
        end
    end

    // Control and output registers; bank memory read is registered into out_pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= 6'd0;
            blk_q       <= '0;
            wbank_q     <= 1'b0;
            bank_st_q   <= '0;
            ibank_q     <= 1'b0;
            iaddr_q     <= '0;
            icol_q      <= '0;
            rbank_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eos_q   <= 1'b0;
            overflow_q  <= 1'b0;
            out_pixel_q <= 8'd0;
        end else begin
            k_q         <= k_d;
            blk_q       <= blk_d;
            wbank_q     <= wbank_d;
            bank_st_q   <= bank_st_d;
            ibank_q     <= ibank_d;
            iaddr_q     <= iaddr_d;
            icol_q      <= icol_d;
            rbank_q     <= rbank_d;
            out_valid_q <= out_valid_d;
            out_eol_q   <= out_eol_d;
            out_eos_q   <= out_eos_d;
            overflow_q  <= overflow_d;
            if (sof) begin
                out_pixel_q <= 8'd0;
            end else if (issue_s) begin
                out_pixel_q <= mem_q[{ibank_q, iaddr_q}];
            end
        end
    end

    // Strip bank write port
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[{wbank_q, waddr_s}] <= level_shift_clamp(pixel_in);
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_eol   = out_eol_q;
    assign out_eos   = out_eos_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_jpeg_block_raster_buffer.sv
// Self-checking bench: random/directed strips compared against a raster reference model.
module tb_jpeg_block_raster_buffer;
    localparam int BPR = 2;
    localparam int W   = 8 * BPR;
    localparam int S   = 8 * W;

    logic       clk, rst_n, sof, pixel_valid, out_valid, out_ready, out_eol, out_eos, overflow;
    logic [8:0] pixel_in;
    logic [7:0] out_pixel;
    int         n_chk = 0;
    int         n_pass = 0;

    jpeg_block_raster_buffer #(.BLOCKS_PER_ROW(BPR)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_eol(out_eol), .out_eos(out_eos), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] ref_clamp(input logic [8:0] p);
        int v;
        v = int'($signed(p)) + 128;
        if (v < 0) return 8'd0;
        else if (v > 255) return 8'd255;
        else return 8'(v);
    endfunction

    // pattern 0: random, 1: ramp (block b pixel k = b*64+k-128), 2: random with clamp corner values
    function automatic logic [8:0] gen_px(input int pattern, input int idx);
        int pos;
        pos = idx % S;
        if (pattern == 1) return 9'(pos - 128);
        if (pattern == 2) begin
            case (pos)
                0:       return 9'h180;
                9:       return 9'h07F;
                40:      return 9'h100;
                41:      return 9'h0FF;
                70:      return 9'h138;
                127:     return 9'h0C8;
                default: ;
            endcase
        end
        return 9'($urandom_range(0, 511));
    endfunction

    // mode 0: ready=1, 1: 10-cycle stall at output stall_at, 2: ready=0 until input done
    task automatic run(input int nstrips, input int extra, input int pattern, input int mode,
                       input int stop_after, input int stall_at, input bit check_lat,
                       input string name);
        logic [8:0] stim[$];
        logic [9:0] expq[$];
        logic [7:0] e;
        int         total, line, col, src, accepted, gaps, cyc, stall;
        bit         fed, rdy;
        total = nstrips * S + extra;
        for (int i = 0; i < total; i++) stim.push_back(gen_px(pattern, i));
        for (int s = 0; s < nstrips; s++) begin
            for (int r = 0; r < S; r++) begin
                line = r / W;
                col  = r % W;
                src  = s * S + (col / 8) * 64 + line * 8 + (col % 8);
                e    = ref_clamp(stim[src]);
                expq.push_back({e, col == W - 1, r == S - 1});
            end
        end
        if (stop_after < 0) stop_after = expq.size();
        fed = 1'b0;
        accepted = 0;
        gaps = 0;
        fork
            begin
                for (int i = 0; i < total; i++) begin
                    @(negedge clk);
                    pixel_valid = 1'b1;
                    pixel_in    = stim[i];
                end
                @(negedge clk);
                pixel_valid = 1'b0;
                fed = 1'b1;
                if (check_lat) begin
                    chk({name, " lat+1"}, 32'(out_valid), 32'd0);
                    @(negedge clk);
                    chk({name, " lat+2"}, 32'(out_valid), 32'd1);
                end
            end
            begin
                cyc = 0;
                stall = 0;
                while (accepted < stop_after && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    case (mode)
                        1:       rdy = !(accepted >= stall_at && stall < 10);
                        2:       rdy = fed;
                        default: rdy = 1'b1;
                    endcase
                    if (!rdy) stall++;
                    out_ready = rdy;
                    if (out_valid) begin
                        chk(rdy ? {name, " out"} : {name, " hold"},
                            32'({out_pixel, out_eol, out_eos}), 32'(expq[accepted]));
                        if (rdy) accepted++;
                    end else if (accepted > 0) begin
                        gaps++;
                    end
                end
                chk({name, " count"}, 32'(accepted), 32'(stop_after));
                if (mode == 0) chk({name, " gaps"}, 32'(gaps), 32'd0);
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
    endtask

    initial begin
        rst_n       = 1'b0;
        sof         = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = 9'd0;
        out_ready   = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_pixel", 32'(out_pixel), 32'd0);
        chk("rst out_eol", 32'(out_eol), 32'd0);
        chk("rst out_eos", 32'(out_eos), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(1, 0, 2, 0, -1, 0, 1'b1, "clamp");
        chk("clamp idle", 32'(out_valid), 32'd0);
        run(1, 0, 1, 0, -1, 0, 1'b1, "reorder");
        chk("reorder idle", 32'(out_valid), 32'd0);
        run(1, 0, 0, 1, -1, 37, 1'b1, "backpressure");
        chk("backpressure ovf", 32'(overflow), 32'd0);
        run(2, 0, 0, 0, -1, 0, 1'b0, "pingpong");
        chk("pingpong ovf", 32'(overflow), 32'd0);
        chk("pingpong idle", 32'(out_valid), 32'd0);

        run(2, 1, 0, 2, -1, 0, 1'b0, "overflow");
        chk("ovf set", 32'(overflow), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf sticky", 32'(overflow), 32'd1);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        chk("ovf sof clear", 32'(overflow), 32'd0);

        run(2, 1, 0, 2, 50, 0, 1'b0, "rst pre");
        chk("rst pre valid", 32'(out_valid), 32'd1);
        chk("rst pre ovf", 32'(overflow), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst mid valid", 32'(out_valid), 32'd0);
        chk("rst mid ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 0, 0, 0, -1, 0, 1'b1, "after rst");
        repeat (5) @(negedge clk);
        chk("after rst idle", 32'(out_valid), 32'd0);

        run(2, 1, 0, 2, 50, 0, 1'b0, "sof pre");
        chk("sof pre valid", 32'(out_valid), 32'd1);
        chk("sof pre ovf", 32'(overflow), 32'd1);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        chk("sof mid valid", 32'(out_valid), 32'd0);
        chk("sof mid ovf", 32'(overflow), 32'd0);
        run(1, 0, 0, 0, -1, 0, 1'b1, "after sof");
        repeat (5) @(negedge clk);
        chk("after sof idle", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
